// File: rtl/mips_multicycle_ctrl.sv
// Multicycle sequencer for the MIPS core: steps the shared datapath through
// fetch/decode/execute/memory/writeback over one unified memory port.
module mips_multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        except,
    input  logic [1:0]  control_type,
    input  logic        mem_read,
    input  logic        word_we,
    input  logic        byte_we,
    input  logic        writeenable,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic        ir_we,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        rf_we,
    output logic        halted,
    output logic        bus_error,
    output logic [31:0] retired,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [7:0] TIMEOUT_M1 = 8'(MEM_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] retired_q, retired_d;
    logic        bus_error_q, bus_error_d;

    logic pc_we_c, ir_we_c, mem_req_c, mem_we_c, mem_addr_sel_c, rf_we_c, halted_c;
    logic retire, expire, timeout_hit, mem_op;

    // The next-PC selector is consumed by the datapath only.
    logic unused_control_type;
    assign unused_control_type = ^control_type;

    assign timeout_hit = (wait_cnt_q == TIMEOUT_M1);
    assign mem_op      = mem_read | word_we | byte_we;

    always_comb begin
        state_d        = state_q;
        pc_we_c        = 1'b0;
        ir_we_c        = 1'b0;
        mem_req_c      = 1'b0;
        mem_we_c       = 1'b0;
        mem_addr_sel_c = 1'b0;
        rf_we_c        = 1'b0;
        halted_c       = 1'b0;
        retire         = 1'b0;
        expire         = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                if (mem_ready) begin
                    ir_we_c = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    expire  = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_DECODE: state_d = except ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (mem_op) begin
                    state_d = S_MEM;
                end else if (writeenable) begin
                    state_d = S_WB;
                end else begin
                    pc_we_c = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                mem_req_c      = 1'b1;
                mem_addr_sel_c = 1'b1;
                mem_we_c       = word_we | byte_we;
                if (mem_ready) begin
                    if (mem_read) begin
                        state_d = S_WB;
                    end else begin
                        pc_we_c = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (timeout_hit) begin
                    expire  = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_WB: begin
                rf_we_c = 1'b1;
                pc_we_c = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT:  halted_c = 1'b1;
            default: state_d  = S_HALT;
        endcase

        // Any state change (into FETCH or MEM in particular) restarts the watchdog.
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (mem_req_c && !mem_ready) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end

        retired_d   = retired_q + {31'd0, retire};
        bus_error_d = bus_error_q | expire;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_FETCH;
            wait_cnt_q  <= '0;
            retired_q   <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            retired_q   <= retired_d;
            bus_error_q <= bus_error_d;
        end
    end

    // Strobes react to mem_ready within the cycle, so they are decoded, not
    // registered; reset masks every output immediately.
    always_comb begin
        pc_we        = pc_we_c & ~reset;
        ir_we        = ir_we_c & ~reset;
        mem_req      = mem_req_c & ~reset;
        mem_we       = mem_we_c & ~reset;
        mem_addr_sel = mem_addr_sel_c & ~reset;
        rf_we        = rf_we_c & ~reset;
        halted       = halted_c & ~reset;
        bus_error    = bus_error_q & ~reset;
        retired      = reset ? '0 : retired_q;
        state        = reset ? 3'd0 : state_q;
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-instruction expected traces are built
// from the instruction class and memory wait pattern, then replayed cycle by cycle.
module tb_mips_multicycle_ctrl;

    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        except = 1'b0;
    logic [1:0]  control_type = 2'd0;
    logic        mem_read = 1'b0, word_we = 1'b0, byte_we = 1'b0, writeenable = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_we, ir_we, mem_req, mem_we, mem_addr_sel, rf_we, halted, bus_error;
    logic [31:0] retired;
    logic [2:0]  state;

    mips_multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .except(except), .control_type(control_type),
        .mem_read(mem_read), .word_we(word_we), .byte_we(byte_we),
        .writeenable(writeenable), .mem_ready(mem_ready), .pc_we(pc_we),
        .ir_we(ir_we), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .rf_we(rf_we), .halted(halted),
        .bus_error(bus_error), .retired(retired), .state(state)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_retired = 32'd0;

    typedef struct {
        logic [2:0] st;
        logic rdy, ir, pc, rf, req, we, asel, hlt, berr, retire;
    } cyc_t;
    cyc_t plan[$];

    typedef struct {
        string name;
        logic  mr, ww, bw, we, ex;
        int    fw, mw;
        int    exp_cycles, exp_ir, exp_rf;
        logic  exp_halt, exp_berr;
    } vec_t;
    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic cyc_t mk(input logic [2:0] st);
        cyc_t c = '{default: 1'b0, st: 3'd0};
        c.st  = st;
        c.rdy = 1'($urandom_range(0, 1));
        return c;
    endfunction

    task automatic add_wait(input logic [2:0] st, input int waits, input logic we_flag,
                            output bit expired);
        cyc_t c;
        int n = (waits >= TO) ? TO : waits;
        expired = 1'b0;
        for (int i = 0; i < n; i++) begin
            c = mk(st); c.rdy = 1'b0; c.req = 1'b1; c.asel = (st == 3'd3); c.we = we_flag;
            plan.push_back(c);
        end
        if (waits >= TO) begin
            expired = 1'b1;
        end else begin
            c = mk(st); c.rdy = 1'b1; c.req = 1'b1; c.asel = (st == 3'd3); c.we = we_flag;
            c.ir = (st == 3'd0);
            plan.push_back(c);
        end
    endtask

    task automatic add_halt(input logic berr);
        cyc_t c;
        for (int i = 0; i < 2; i++) begin
            c = mk(3'd5); c.hlt = 1'b1; c.berr = berr;
            plan.push_back(c);
        end
    endtask

    task automatic build_plan(input logic mr, ww, bw, we, ex, input int fw, mw);
        cyc_t c;
        bit exp;
        logic is_mem = mr | ww | bw;
        logic br = !is_mem && !we;
        plan.delete();
        add_wait(3'd0, fw, 1'b0, exp);
        if (exp) begin add_halt(1'b1); return; end
        plan.push_back(mk(3'd1));
        if (ex) begin add_halt(1'b0); return; end
        c = mk(3'd2); c.pc = br; c.retire = br;
        plan.push_back(c);
        if (br) return;
        if (is_mem) begin
            add_wait(3'd3, mw, ww | bw, exp);
            if (exp) begin add_halt(1'b1); return; end
            if (!mr) begin
                c = plan.pop_back(); c.pc = 1'b1; c.retire = 1'b1;
                plan.push_back(c);
                return;
            end
        end
        c = mk(3'd4); c.rf = 1'b1; c.pc = 1'b1; c.retire = 1'b1;
        plan.push_back(c);
    endtask

    task automatic run_plan(input logic mr, ww, bw, we, ex, input int force_at, input int max_cyc,
                            output int first_evt, output int n_ir, output int n_rf,
                            output logic berr_end, output logic hlt_end,
                            output logic [31:0] ret_first);
        first_evt = 0; n_ir = 0; n_rf = 0; ret_first = '0;
        for (int i = 0; i < plan.size() && i < max_cyc; i++) begin
            @(negedge clock);
            reset = 1'b0;
            mem_read = mr; word_we = ww; byte_we = bw; writeenable = we; except = ex;
            control_type = 2'($urandom_range(0, 3));
            mem_ready = plan[i].rdy;
            if (i == force_at) begin
                force dut.retired_q = 32'hFFFF_FFFF;
                exp_retired = 32'hFFFF_FFFF;
            end
            if (i == force_at + 1) release dut.retired_q;
            #1;
            check($sformatf("cycle%0d", i),
                  {21'd0, state, ir_we, pc_we, rf_we, mem_req, mem_we, mem_addr_sel,
                   halted, bus_error, retired},
                  {21'd0, plan[i].st, plan[i].ir, plan[i].pc, plan[i].rf, plan[i].req,
                   plan[i].we, plan[i].asel, plan[i].hlt, plan[i].berr, exp_retired});
            if (i == 0) ret_first = retired;
            if ((pc_we || halted) && first_evt == 0) first_evt = i + 1;
            n_ir += int'(ir_we);
            n_rf += int'(rf_we);
            if (plan[i].retire) exp_retired = exp_retired + 32'd1;
        end
        berr_end = bus_error;
        hlt_end  = halted;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
        #1;
        check("reset_outs_pre", {21'd0, pc_we, ir_we, mem_req, mem_we, mem_addr_sel, rf_we,
              halted, bus_error, retired, state}, 64'd0);
        @(negedge clock);
        mem_ready = 1'b1;
        #1;
        check("reset_outs_post", {21'd0, pc_we, ir_we, mem_req, mem_we, mem_addr_sel, rf_we,
              halted, bus_error, retired, state}, 64'd0);
        exp_retired = 32'd0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int fe, nir, nrf, fw, mw, cls;
        logic be, he, ex, mr, ww, bw, we;
        logic [31:0] rf0;

        vecs[0]  = '{"alu",             0,0,0,1,0, 0,0, 4,1,1, 0,0};
        vecs[1]  = '{"load_w3",         1,0,0,1,0, 0,3, 8,1,1, 0,0};
        vecs[2]  = '{"sb",              0,0,1,0,0, 0,0, 4,1,0, 0,0};
        vecs[3]  = '{"sw_f2",           0,1,0,0,0, 2,0, 6,1,0, 0,0};
        vecs[4]  = '{"branch",          0,0,0,0,0, 0,0, 3,1,0, 0,0};
        vecs[5]  = '{"load",            1,0,0,1,0, 0,0, 5,1,1, 0,0};
        vecs[6]  = '{"except",          0,0,0,1,1, 0,0, 3,1,0, 1,0};
        vecs[7]  = '{"wdog_fetch",      0,0,0,1,0, 4,0, 5,0,0, 1,1};
        vecs[8]  = '{"wdog_late_ready", 0,0,0,1,0, 3,0, 7,1,1, 0,0};
        vecs[9]  = '{"wdog_mem",        1,0,0,1,0, 0,4, 8,1,0, 1,1};
        vecs[10] = '{"sw_m3",           0,1,0,0,0, 1,3, 8,1,0, 0,0};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            build_plan(vecs[i].mr, vecs[i].ww, vecs[i].bw, vecs[i].we, vecs[i].ex,
                       vecs[i].fw, vecs[i].mw);
            run_plan(vecs[i].mr, vecs[i].ww, vecs[i].bw, vecs[i].we, vecs[i].ex, -1, 1000,
                     fe, nir, nrf, be, he, rf0);
            check({vecs[i].name, "_cycles"}, 64'(fe), 64'(vecs[i].exp_cycles));
            check({vecs[i].name, "_ir_we"}, 64'(nir), 64'(vecs[i].exp_ir));
            check({vecs[i].name, "_rf_we"}, 64'(nrf), 64'(vecs[i].exp_rf));
            check({vecs[i].name, "_halt_berr"}, {62'd0, he, be},
                  {62'd0, vecs[i].exp_halt, vecs[i].exp_berr});
            if (vecs[i].exp_halt) do_reset();
        end

        // Counter wrap: retired forced to all-ones during DECODE, then one retire.
        build_plan(0, 0, 0, 1, 0, 0, 0);
        run_plan(0, 0, 0, 1, 0, 1, 1000, fe, nir, nrf, be, he, rf0);
        build_plan(0, 0, 0, 0, 0, 0, 0);
        run_plan(0, 0, 0, 0, 0, -1, 1000, fe, nir, nrf, be, he, rf0);
        check("wrap", 64'(rf0), 64'd0);

        // Reset while a load waits in MEM, with mem_ready arriving in the reset cycle.
        build_plan(0, 0, 0, 1, 0, 0, 0);
        run_plan(0, 0, 0, 1, 0, -1, 1000, fe, nir, nrf, be, he, rf0);
        build_plan(1, 0, 0, 1, 0, 0, 3);
        run_plan(1, 0, 0, 1, 0, -1, 5, fe, nir, nrf, be, he, rf0);
        @(negedge clock);
        reset = 1'b1; mem_ready = 1'b1;
        #1;
        check("rst_mid_pc_we", 64'(pc_we), 64'd0);
        check("rst_mid_mem_req", 64'(mem_req), 64'd0);
        @(negedge clock);
        reset = 1'b0; mem_ready = 1'b0;
        #1;
        check("rst_mid_state", 64'(state), 64'd0);
        check("rst_mid_retired", 64'(retired), 64'd0);
        check("rst_mid_fetch_req", {62'd0, mem_req, pc_we}, 64'd2);
        do_reset();

        for (int n = 0; n < 150; n++) begin
            cls = $urandom_range(0, 5);
            mr = (cls == 1); ww = (cls == 2); bw = (cls == 3);
            we = (cls == 0) || (cls == 1) || (cls == 5);
            ex = ($urandom_range(0, 19) == 0);
            fw = ($urandom_range(0, 15) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
            mw = ($urandom_range(0, 15) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
            build_plan(mr, ww, bw, we, ex, fw, mw);
            run_plan(mr, ww, bw, we, ex, -1, 1000, fe, nir, nrf, be, he, rf0);
            if (plan[plan.size() - 1].hlt) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle sequencer for the MIPS core: a finite state machine (FSM) that steps the shared datapath through fetch, decode, execute, memory and writeback over several cycles, so that a single unified memory port serves both instruction and data traffic. It consumes the decoder's control outputs (`except`, `control_type`, `mem_read`, `word_we`, `byte_we`, `writeenable`). It produces per-cycle strobes for the PC, the instruction register (IR), the register file and the memory port. It also runs a memory-response watchdog and counts retired instructions.

## Interface
- `MEM_TIMEOUT`, default 16: maximum number of consecutive cycles one memory request may wait for `mem_ready`. Legal range 1..255.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `except`  in  1: decoder flags an unrecognised instruction; valid in DECODE.
- `control_type`  in  2: decoder next-PC selector; consumed by the datapath, not the FSM.
- `mem_read`  in  1: instruction is a load.
- `word_we`  in  1: instruction is a word store.
- `byte_we`  in  1: instruction is a byte store.
- `writeenable`  in  1: instruction writes the register file.
- `mem_ready`  in  1: memory response/accept. Meaningful only while `mem_req`=1.
- `pc_we`  out  1: latch next PC (datapath selects the value via `control_type`).
- `ir_we`  out  1: latch the fetched word into the IR.
- `mem_req`  out  1: memory request active.
- `mem_we`  out  1: request is a store.
- `mem_addr_sel`  out  1: memory address source; 0 = PC, 1 = ALU result.
- `rf_we`  out  1: register-file write strobe.
- `halted`  out  1: FSM is in HALT.
- `bus_error`  out  1: sticky flag, set on watchdog expiry.
- `retired`  out  32: retired-instruction count.
- `state`  out  3: current state, for debug.

## Operation
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 go to HALT on the next cycle.
- Strobes are decoded from the registered state plus `mem_ready`. Any strobe not listed for a state is 0.
- **FETCH**
  - `mem_req`=1, `mem_addr_sel`=0, `mem_we`=0.
  - On `mem_ready`=1: `ir_we`=1 in that same cycle, then go to DECODE.
- **DECODE**
  - One cycle. Decoder inputs are sampled here.
  - `except`=1 goes to HALT. No strobes are issued and `retired` does not increment.
  - Otherwise go to EXEC.
- **EXEC** (ALU evaluates)
  - `mem_read|word_we|byte_we` goes to MEM.
  - Else `writeenable` goes to WB.
  - Else (branch, `j`, `jr`): `pc_we`=1, `retired`+1, go to FETCH.
- **MEM**
  - `mem_req`=1, `mem_addr_sel`=1, `mem_we`=`word_we|byte_we`.
  - On `mem_ready`, a load goes to WB.
  - On `mem_ready`, a store drives `pc_we`=1 and `retired`+1, then goes to FETCH.
- **WB**
  - `rf_we`=1, `pc_we`=1, `retired`+1, go to FETCH.
- **HALT**
  - All strobes 0, `halted`=1.
  - Absorbing: only `reset` exits.
- **Watchdog**
  - 8-bit `wait_cnt` clears on every entry to FETCH or MEM.
  - It increments each cycle that `mem_req`=1 and `mem_ready`=0.
  - When `mem_ready`=0 and `wait_cnt`==`MEM_TIMEOUT`-1: go to HALT and set `bus_error`=1.
  - `mem_ready`=1 in the expiry cycle wins: the response is accepted and there is no error.
- **Counter and reset**
  - `retired` wraps from 0xFFFFFFFF to 0.
  - `mem_ready` outside FETCH/MEM is ignored.
  - `reset` in any state, including mid-request, forces FETCH, `wait_cnt`=0, `retired`=0, `bus_error`=0.

## Timing
- While `reset`=1: every output is 0. This includes `mem_req`, `halted`, `bus_error`, `retired`, and `state`=0.
- First cycle after `reset` deasserts: FETCH with `mem_req`=1.
- Cycles per instruction with zero-wait memory (`mem_ready` high whenever requested):

  | Instruction class | Cycles |
  |---|---|
  | Branch / jump | 3 |
  | ALU / `lui` / `slt` | 4 |
  | Store | 4 |
  | Load | 5 |

- Each wait cycle adds one cycle in FETCH or MEM.
- `pc_we` pulses exactly once per retired instruction, in its final cycle, coincident with the `retired` increment (the count is visible on the next edge).
- `ir_we` pulses exactly once per instruction.
- `rf_we` and `pc_we` are never asserted in FETCH, DECODE or HALT.

## Test plan
- **ALU instruction:** reset; `mem_ready`=1 constantly; instruction `writeenable`=1, others 0.
  - Expected states 0, 1, 2, 4, 0.
  - `ir_we` in cycle 1; `rf_we` and `pc_we` in cycle 4; `retired` becomes 1.
- **Load with waits:** `mem_read`=1, and `mem_ready` held low for 3 MEM cycles.
  - Expected 8-cycle instruction: MEM lasts 4 cycles with `mem_addr_sel`=1 and `mem_we`=0.
  - Then WB with `rf_we`=1.
- **Store and branch:** byte store with `byte_we`=1.
  - Expected `mem_we`=1 in MEM, no `rf_we`, and `pc_we` on the `mem_ready` cycle.
  - Branch with all flags 0: `pc_we` in EXEC, 3 cycles total.
- **Exception:** `except`=1 in DECODE.
  - Expected HALT next cycle, `halted`=1, `retired` unchanged, no further `mem_req`.
  - Asserting `reset` returns the FSM to FETCH.
- **Watchdog (`MEM_TIMEOUT`=4):**
  - `mem_ready`=0 for 4 FETCH cycles: expect HALT with `bus_error`=1.
  - Repeat with `mem_ready`=1 in the 4th cycle: expect `ir_we`=1, DECODE, `bus_error`=0.
- **Wrap and reset mid-request:**
  - Force `retired` to 0xFFFFFFFF and retire one instruction: expect 0.
  - Assert `reset` during MEM wait: next cycle FETCH, `retired`=0, no `pc_we`.
